// File: rtl/ntt_pkg.sv
// Shared types for the NTT stage scheduler: FSM state encoding and the
// width of the write-strobe delay line.
package ntt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int WR_DLY_W = 1;

endpackage

// File: rtl/shiftreg.sv
// Fixed-depth delay line with synchronous clear; dout is din delayed by
// exactly DELAY clock cycles.
module shiftreg #(
  parameter int DELAY = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_r [DELAY];

  // shift the delay line, clearing every tap on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < DELAY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign dout = pipe_r[DELAY-1];

endmodule

// File: rtl/ntt_scheduler.sv
// NTT stage scheduler: sequences LOGN butterfly stages over PE units.
// Optional performance counters are enabled with NTT_SCHED_PERF_EN.
module ntt_scheduler #(
  parameter int LOGN    = 8,
  parameter int PE      = 4,
  parameter int LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  input  logic                    start_inv,
  output logic                    start_ready,
  output logic                    agu_rst,
  output logic                    agu_is_nr,
  input  logic                    agu_done,
  output logic [$clog2(LOGN)-1:0] stage,
  output logic                    rd_bank,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic                    err
`ifdef NTT_SCHED_PERF_EN
  ,
  output logic [31:0]             cycles,
  output logic [15:0]             jobs
`endif
);
  import ntt_pkg::*;

  localparam int N   = 1 << LOGN;
  localparam int CPS = N / (2 * PE);
  localparam int CW  = $clog2(CPS);
  localparam int SW  = $clog2(LOGN);
  localparam int DW  = $clog2(LATENCY + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(CPS - 1);
  localparam logic [CW-1:0] CYC_ONE    = CW'(1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOGN - 1);
  localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  state_t                state_r;
  logic [CW-1:0]         cyc_r;
  logic [DW-1:0]         dcnt_r;
  logic [SW-1:0]         stage_r;
  logic                  start_ready_r;
  logic                  agu_rst_r;
  logic                  agu_is_nr_r;
  logic                  rd_en_r;
  logic                  done_valid_r;
  logic                  err_r;
  logic                  last_s;
  logic [WR_DLY_W-1:0]   wr_en_s;

  assign last_s = (stage_r == STAGE_LAST) && (cyc_r == CYC_LAST);

  // job sequencer; outputs are registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cyc_r         <= {CW{1'b0}};
      dcnt_r        <= {DW{1'b0}};
      stage_r       <= {SW{1'b0}};
      start_ready_r <= 1'b1;
      agu_rst_r     <= 1'b1;
      agu_is_nr_r   <= 1'b0;
      rd_en_r       <= 1'b0;
      done_valid_r  <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      // agu_done must coincide exactly with the final RUN cycle
      if (state_r == ST_RUN && (agu_done != last_s)) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_valid && start_ready_r) begin
            state_r       <= ST_LOAD;
            agu_is_nr_r   <= start_inv;
            start_ready_r <= 1'b0;
            stage_r       <= {SW{1'b0}};
          end
        end
        ST_LOAD: begin
          state_r   <= ST_RUN;
          agu_rst_r <= 1'b0;
          rd_en_r   <= 1'b1;
          cyc_r     <= {CW{1'b0}};
        end
        ST_RUN: begin
          if (last_s) begin
            state_r   <= ST_DRAIN;
            agu_rst_r <= 1'b1;
            rd_en_r   <= 1'b0;
            dcnt_r    <= {DW{1'b0}};
          end else if (cyc_r == CYC_LAST) begin
            cyc_r   <= {CW{1'b0}};
            stage_r <= stage_r + STAGE_ONE;
          end else begin
            cyc_r <= cyc_r + CYC_ONE;
          end
        end
        ST_DRAIN: begin
          if (dcnt_r == DRAIN_LAST) begin
            state_r      <= ST_DONE;
            done_valid_r <= 1'b1;
          end else begin
            dcnt_r <= dcnt_r + DRAIN_ONE;
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            state_r       <= ST_IDLE;
            done_valid_r  <= 1'b0;
            start_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          start_ready_r <= 1'b1;
          agu_rst_r     <= 1'b1;
          rd_en_r       <= 1'b0;
          done_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  shiftreg #(
    .DELAY (LATENCY),
    .WIDTH (WR_DLY_W)
  ) u_wr_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en_r),
    .dout (wr_en_s)
  );

`ifdef NTT_SCHED_PERF_EN
  logic [31:0] cycles_r;
  logic [15:0] jobs_r;

  // per-job busy-cycle counter and completed-job counter, both wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_r <= 32'd0;
      jobs_r   <= 16'd0;
    end else begin
      if (state_r == ST_IDLE && start_valid && start_ready_r) begin
        cycles_r <= 32'd0;
      end else if (state_r != ST_IDLE) begin
        cycles_r <= cycles_r + 32'd1;
      end
      if (state_r == ST_DONE && done_ready) begin
        jobs_r <= jobs_r + 16'd1;
      end
    end
  end

  assign cycles = cycles_r;
  assign jobs   = jobs_r;
`endif

  assign start_ready = start_ready_r;
  assign agu_rst     = agu_rst_r;
  assign agu_is_nr   = agu_is_nr_r;
  assign stage       = stage_r;
  assign rd_bank     = stage_r[0];
  assign rd_en       = rd_en_r;
  assign wr_en       = wr_en_s[0];
  assign done_valid  = done_valid_r;
  assign err         = err_r;

endmodule
